fifo_1r1w: RTL and testbench
============================

FIFO_1R1W -- requirements
Module: fifo_1r1w

Interface
REQ-001 The block SHALL have parameter width_p, default 48, meaning the data word width in bits (right 24 bits in [47:24], left 24 bits in [23:0]).
REQ-002 The block SHALL have parameter depth_log2_p, default 4, meaning the storage depth is 2^depth_log2_p entries.
REQ-003 The block SHALL have port clk_i, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_ni, input, width 1, meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port data_i, input, width width_p, meaning the upstream word.
REQ-006 The block SHALL have port valid_i, input, width 1, meaning data_i is valid.
REQ-007 The block SHALL have port ready_and_o, output, width 1, meaning the FIFO accepts a word this cycle.
REQ-008 The block SHALL have port data_o, output, width width_p, meaning the head word.
REQ-009 The block SHALL have port valid_o, output, width 1, meaning data_o holds a valid head word.
REQ-010 The block SHALL have port ready_i, input, width 1, meaning the downstream consumes data_o this cycle.

Function
REQ-011 The block SHALL define push as valid_i & ready_and_o and pop as valid_o & ready_i.
REQ-012 The block SHALL drive ready_and_o = !full from registered state only, with no combinational path from valid_i or ready_i.
REQ-013 The block SHALL drive valid_o = !empty from registered state, except as REQ-026 allows.
REQ-014 The block SHALL keep write and read pointers of depth_log2_p+1 bits; both wrap modulo 2^(depth_log2_p+1).
REQ-015 Empty SHALL mean the pointers are equal; full SHALL mean the low bits are equal and the MSBs differ.
REQ-016 On push, the block SHALL write data_i at the write pointer's low bits and increment the write pointer.
REQ-017 On pop, the block SHALL increment the read pointer.
REQ-018 The block SHALL drive data_o combinationally from storage at the read pointer's low bits.
REQ-019 data_o SHALL be don't-care while valid_o=0.
REQ-020 A word pushed in cycle N SHALL appear on data_o with valid_o=1 in cycle N+1 when the FIFO was empty.
REQ-021 When not full and not empty, simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-022 When full, a pop SHALL be honoured and ready_and_o SHALL rise in the next cycle; a word offered in the full cycle is not accepted.
REQ-023 When empty, ready_i SHALL have no effect.
REQ-024 Words SHALL leave in strict arrival order, with no loss or duplication.

Reset
REQ-025 While reset_ni=0 the block SHALL asynchronously clear both pointers, giving valid_o=0 and ready_and_o=1; storage contents are not reset, and a reset mid-stream discards all stored words.

Configuration
REQ-026 With macro FIFO_1R1W_BYPASS_EN defined: when empty, if valid_i=1 and ready_i=1 then valid_o=1 and data_o=data_i in the same cycle, no word is stored, and the pointers are unchanged. Without the macro, behaviour SHALL be exactly REQ-013/REQ-020, with no path from data_i to data_o.

Structure
REQ-027 A shared package fifo_pkg SHALL hold the sample width constant (24) and the stereo_sample_t packed struct {right, left}.
REQ-028 Storage SHALL be a sub-module ram_1r1w_async: synchronous write, asynchronous read, width_p by 2^depth_log2_p entries.

Verification
REQ-029 The bench SHALL cover: reset, then push 0x000001_000002 with ready_i=0 -> valid_o=1 next cycle, data_o=0x000001_000002, ready_and_o=1.
REQ-030 The bench SHALL cover: push 16 words 1..16 with ready_i=0 -> ready_and_o=0 after the 16th push; a 17th offered word is dropped; then ready_i=1 drains 1..16 in order.
REQ-031 The bench SHALL cover: full, then valid_i=1 and ready_i=1 in the same cycle -> the pop of word 1 occurs, the push is refused, and ready_and_o=1 the next cycle.
REQ-032 The bench SHALL cover: continuous push and pop at occupancy 3 for 40 cycles -> pointers wrap and the output sequence equals the input sequence.
REQ-033 The bench SHALL cover: reset_ni low mid-stream with occupancy 5 -> valid_o=0 immediately without a clock, and ready_and_o=1.
REQ-034 The bench SHALL cover, with FIFO_1R1W_BYPASS_EN: empty, valid_i=1, ready_i=1, data_i=0xABCDEF_123456 -> same-cycle valid_o=1, data_o=0xABCDEF_123456, and valid_o=0 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the 1R1W FIFO slice.
// A 48-bit stereo word is {right[23:0], left[23:0]}.
package fifo_pkg;

    localparam int unsigned sample_width_lp = 24;

    typedef struct packed {
        logic [sample_width_lp-1:0] right;
        logic [sample_width_lp-1:0] left;
    } stereo_sample_t;

    localparam int unsigned stereo_width_lp = $bits(stereo_sample_t);

endpackage

// File: rtl/ram_1r1w_async.sv
// Register-file storage: synchronous write, asynchronous read.
// Contents are never reset; stale entries are masked by FIFO pointers.
module ram_1r1w_async #(
    parameter int width_p      = 48,
    parameter int addr_width_p = 4,
    parameter int els_p        = 1 << addr_width_p
) (
    input  logic                    clk_i,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // write port: one entry per rising edge when enabled
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/fifo_1r1w.sv
// Valid/ready FIFO over an async-read register file.
// Optional same-cycle empty bypass: define FIFO_1R1W_BYPASS_EN.
module fifo_1r1w
    import fifo_pkg::*;
#(
    parameter int width_p      = stereo_width_lp,
    parameter int depth_log2_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int ptr_w_lp = depth_log2_p + 1;

    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic                empty, full;
    logic                push, pop;
    logic                bypass;
    logic [width_p-1:0]  ram_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[depth_log2_p-1:0] == rd_ptr_q[depth_log2_p-1:0])
                 & (wr_ptr_q[depth_log2_p] != rd_ptr_q[depth_log2_p]);

    assign ready_and_o = ~full;

`ifdef FIFO_1R1W_BYPASS_EN
    // empty and both sides ready: hand data_i straight through
    assign bypass  = empty & valid_i & ready_i;
    assign valid_o = ~empty | bypass;
    assign data_o  = bypass ? data_i : ram_data;
`else
    assign bypass  = 1'b0;
    assign valid_o = ~empty;
    assign data_o  = ram_data;
`endif

    assign push = valid_i & ready_and_o & ~bypass;
    assign pop  = valid_o & ready_i & ~bypass;

    // next-state pointers; each advances by one on its handshake
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
        end
    end

    // pointer registers; reset empties the FIFO
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    ram_1r1w_async #(
        .width_p      (width_p),
        .addr_width_p (depth_log2_p)
    ) u_ram (
        .clk_i    (clk_i),
        .w_v_i    (push),
        .w_addr_i (wr_ptr_q[depth_log2_p-1:0]),
        .w_data_i (data_i),
        .r_addr_i (rd_ptr_q[depth_log2_p-1:0]),
        .r_data_o (ram_data)
    );

endmodule

// File: tb/tb_fifo_1r1w.sv
// Self-checking bench for fifo_1r1w against a queue model.
// Build with FIFO_1R1W_BYPASS_EN to exercise the bypass path.
module tb_fifo_1r1w;
    import fifo_pkg::*;

    localparam int W = 48;
    localparam int D = 16;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_and_o;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         ready_i;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] q[$];

    fifo_1r1w #(.width_p(W), .depth_log2_p(4)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_and_o (ready_and_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] rnd48();
        return {16'($urandom()), $urandom()};
    endfunction

    function automatic logic exp_valid();
`ifdef FIFO_1R1W_BYPASS_EN
        return (q.size() > 0) || (valid_i && ready_i);
`else
        return q.size() > 0;
`endif
    endfunction

    function automatic logic [W-1:0] exp_data();
        if (q.size() > 0) return q[0];
        return data_i;
    endfunction

    task automatic drive(input logic vi, input logic [W-1:0] di, input logic ri);
        valid_i = vi;
        data_i  = di;
        ready_i = ri;
        #1;
    endtask

    // advance one clock, updating the model from the spec rules
    task automatic clock();
        logic do_push, do_pop, byp;
        byp = 1'b0;
`ifdef FIFO_1R1W_BYPASS_EN
        byp = (q.size() == 0) && valid_i && ready_i;
`endif
        do_push = valid_i && (q.size() < D) && !byp;
        do_pop  = (q.size() > 0) && ready_i;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(data_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        ready_i = 1'b0;
        #1;
        vectors++;
        if (valid_o !== 1'b0 || ready_and_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: valid_o=%b ready_and_o=%b want 0/1", valid_o, ready_and_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        q.delete();
        #1;
    endtask

    task automatic test_first_word();
        drive(1'b1, 48'h000001_000002, 1'b0);
        vectors++;
        if (valid_o !== 1'b0 || ready_and_o !== 1'b1) begin
            miscompares++;
            $display("FAIL first_pre: valid_o=%b ready=%b want 0/1", valid_o, ready_and_o);
        end
        clock();
        drive(1'b0, '0, 1'b0);
        vectors++;
        if (valid_o !== 1'b1 || data_o !== 48'h000001_000002 || ready_and_o !== 1'b1) begin
            miscompares++;
            $display("FAIL first_word: valid_o=%b data_o=%h ready=%b want 1/000001000002/1",
                     valid_o, data_o, ready_and_o);
        end
        drive(1'b0, '0, 1'b1);
        clock();
        drive(1'b0, '0, 1'b0);
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL first_drain: valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= D; i++) begin
            drive(1'b1, 48'(i), 1'b0);
            vectors++;
            if (ready_and_o !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready: push %0d ready=%b want 1", i, ready_and_o);
            end
            clock();
        end
        drive(1'b1, 48'd17, 1'b0);
        vectors++;
        if (ready_and_o !== 1'b0 || valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flag: ready=%b valid=%b want 0/1", ready_and_o, valid_o);
        end
        clock();
        for (int i = 1; i <= D; i++) begin
            drive(1'b0, '0, 1'b1);
            vectors++;
            if (valid_o !== 1'b1 || data_o !== 48'(i)) begin
                miscompares++;
                $display("FAIL drain: valid=%b data=%h want 1/%h", valid_o, data_o, 48'(i));
            end
            clock();
        end
        drive(1'b0, '0, 1'b0);
        vectors++;
        if (valid_o !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_empty: valid=%b (word 17 must be dropped) want 0", valid_o);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= D; i++) begin
            drive(1'b1, 48'(i), 1'b0);
            clock();
        end
        drive(1'b1, 48'h99, 1'b1);
        vectors++;
        if (ready_and_o !== 1'b0 || data_o !== 48'd1) begin
            miscompares++;
            $display("FAIL full_pp: ready=%b data=%h want 0/1", ready_and_o, data_o);
        end
        clock();
        drive(1'b0, '0, 1'b0);
        vectors++;
        if (ready_and_o !== 1'b1 || data_o !== 48'd2) begin
            miscompares++;
            $display("FAIL full_pp_next: ready=%b data=%h want 1/2", ready_and_o, data_o);
        end
        while (q.size() > 0) begin
            drive(1'b0, '0, 1'b1);
            vectors++;
            if (valid_o !== 1'b1 || data_o !== q[0]) begin
                miscompares++;
                $display("FAIL full_pp_drain: data=%h want %h", data_o, q[0]);
            end
            clock();
        end
        drive(1'b0, '0, 1'b0);
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pp_empty: valid=%b want 0 (48'h99 must not be stored)", valid_o);
        end
    endtask

    task automatic test_steady();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd48(), 1'b0);
            clock();
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, rnd48(), 1'b1);
            vectors++;
            if (valid_o !== 1'b1 || ready_and_o !== 1'b1 || data_o !== q[0]) begin
                miscompares++;
                $display("FAIL steady: cyc %0d valid=%b data=%h want 1/%h",
                         i, valid_o, data_o, q[0]);
            end
            clock();
        end
        vectors++;
        if (q.size() != 3) begin
            miscompares++;
            $display("FAIL steady_occ: model occupancy %0d want 3", q.size());
        end
        while (q.size() > 0) begin
            drive(1'b0, '0, 1'b1);
            vectors++;
            if (data_o !== q[0]) begin
                miscompares++;
                $display("FAIL steady_drain: data=%h want %h", data_o, q[0]);
            end
            clock();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rnd48(), 1'b0);
            clock();
        end
        drive(1'b0, '0, 1'b0);
        reset_ni = 1'b0;
        #1;
        vectors++;
        if (valid_o !== 1'b0 || ready_and_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b ready=%b want 0/1", valid_o, ready_and_o);
        end
        q.delete();
        #1;
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: valid=%b want 0", valid_o);
        end
    endtask

`ifdef FIFO_1R1W_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 48'hABCDEF_123456, 1'b1);
        vectors++;
        if (valid_o !== 1'b1 || data_o !== 48'hABCDEF_123456) begin
            miscompares++;
            $display("FAIL bypass: valid=%b data=%h want 1/abcdef123456", valid_o, data_o);
        end
        clock();
        drive(1'b0, '0, 1'b0);
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_next: valid=%b want 0", valid_o);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd48(), 1'($urandom_range(0, 2) == 0));
            vectors++;
            if (ready_and_o !== (q.size() < D) || valid_o !== exp_valid()
                || (exp_valid() && data_o !== exp_data())) begin
                miscompares++;
                $display("FAIL random: cyc %0d ready=%b valid=%b data=%h occ=%0d",
                         i, ready_and_o, valid_o, data_o, q.size());
            end
            clock();
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_fill_drain();
        test_full_push_pop();
        test_steady();
        test_reset_mid();
`ifdef FIFO_1R1W_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
